// File: rtl/riscv_cpu_pkg.sv
// Shared types and constants for the riscv_cpu front end.
package riscv_cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_BOOT_ADDR = 32'h0000_0080;

   // One buffered fetch result: the instruction word and the PC it came from.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Force an address onto a 32-bit word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for fetch_stage: synchronous FIFO of fetch_entry_t
// with push, pop and a single-cycle flush. DEPTH must be a power of two.
module fetch_fifo
   import riscv_cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t data_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic         empty_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full_s;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full_s    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   // A push into a full buffer is only taken when the head leaves in the same cycle.
   assign push_ok_s = push_i & (~full_s | pop_i);
   assign pop_ok_s  = pop_i & ~empty_o;

   // Storage, pointers and occupancy; flush empties without touching storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   fetch_fifo_chk u_chk (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push_i & ~flush_i),
      .pop_i  (pop_i),
      .full_i (full_s)
   );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Checker for fetch_fifo: a push into a full buffer with no pop in the
// same cycle would overwrite the oldest instruction.
module fetch_fifo_chk (
   input logic clk_i,
   input logic rst_i,
   input logic push_i,
   input logic pop_i,
   input logic full_i
);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && full_i && !pop_i));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a
// req/gnt/rvalid handshake, buffers returned words and hands them to
// control_unit with valid/ready. Redirects flush buffered words and drop
// the responses of requests already in flight.
// Optional build macro FETCH_BYPASS_EN: an arriving word is presented in the
// same cycle when the buffer is empty (zero-latency path).
module fetch_stage
   import riscv_cpu_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_en_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i
);

   localparam int         CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic          hold_q, hold_d;            // request raised but not yet granted
   logic [31:0]   hold_addr_q, hold_addr_d;
   logic          hold_redir_q, hold_redir_d; // held request was overtaken by a redirect

   logic [CW-1:0] fifo_count_s;
   logic          fifo_empty_s;
   fetch_entry_t  fifo_head_s;
   fetch_entry_t  fifo_in_s;
   logic          push_s;
   logic          pop_s;
   logic          credit_ok_s;
   logic          req_s;
   logic [31:0]   addr_s;
   logic          fire_s;
   logic          accept_s;
   logic [31:0]   target_s;

   // Credit counts buffered plus in-flight words; same-cycle pops are not credited.
   assign credit_ok_s = ({1'b0, fifo_count_s} + {1'b0, outstanding_q}) < DEPTH_W;
   assign req_s       = ~rst_i & (hold_q | (fetch_en_i & credit_ok_s));
   assign addr_s      = hold_q ? hold_addr_q : fetch_pc_q;
   assign fire_s      = req_s & imem_gnt_i;
   assign accept_s    = imem_rvalid_i & (discard_q == '0) & ~redirect_i;
   assign target_s    = word_align(redirect_addr_i);
   assign fifo_in_s   = '{instr: imem_rdata_i, pc: resp_pc_q};
   assign pop_s       = ~fifo_empty_s & instr_ready_i & ~redirect_i;

   assign imem_req_o  = req_s;
   assign imem_addr_o = addr_s;

`ifdef FETCH_BYPASS_EN
   logic bypass_s;
   assign bypass_s      = accept_s & fifo_empty_s;
   assign instr_valid_o = ~fifo_empty_s | bypass_s;
   assign instr_o       = fifo_empty_s ? imem_rdata_i : fifo_head_s.instr;
   assign instr_pc_o    = fifo_empty_s ? resp_pc_q : fifo_head_s.pc;
   assign push_s        = accept_s & ~(bypass_s & instr_ready_i);
`else
   assign instr_valid_o = ~fifo_empty_s;
   assign instr_o       = fifo_head_s.instr;
   assign instr_pc_o    = fifo_head_s.pc;
   assign push_s        = accept_s;
`endif

   // Next-state for PCs, in-flight/discard counters and the held-request latch.
   always_comb begin
      outstanding_d = outstanding_q + CW'(fire_s) - CW'(imem_rvalid_i);
      hold_d        = req_s & ~imem_gnt_i;
      hold_redir_d  = hold_d & (hold_redir_q | redirect_i);
      if (hold_d) begin
         hold_addr_d = addr_s;
      end else begin
         hold_addr_d = hold_addr_q;
      end
      if (redirect_i) begin
         fetch_pc_d = target_s;
      end else if (fire_s && !hold_redir_q) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
      if (redirect_i) begin
         resp_pc_d = target_s;
      end else if (accept_s) begin
         resp_pc_d = resp_pc_q + 32'd4;
      end else begin
         resp_pc_d = resp_pc_q;
      end
      if (redirect_i) begin
         discard_d = outstanding_d + CW'(hold_d);
      end else if (imem_rvalid_i && (discard_q != '0)) begin
         discard_d = discard_q - CW'(1);
      end else begin
         discard_d = discard_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q    <= BOOT_ADDR;
         resp_pc_q     <= BOOT_ADDR;
         outstanding_q <= '0;
         discard_q     <= '0;
         hold_q        <= 1'b0;
         hold_addr_q   <= 32'h0000_0000;
         hold_redir_q  <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         hold_q        <= hold_d;
         hold_addr_q   <= hold_addr_d;
         hold_redir_q  <= hold_redir_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (redirect_i),
      .push_i  (push_s),
      .data_i  (fifo_in_s),
      .pop_i   (pop_s),
      .head_o  (fifo_head_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (default build). The bench
// plays the memory itself: every cycle's gnt/rvalid/rdata is in the vector.
module tb_fetch_stage;

   typedef struct packed {
      logic        en;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        redir;
      logic [31:0] raddr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t tbl [15];

   fetch_stage dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .fetch_en_i      (fetch_en),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_gnt_i      (imem_gnt),
      .imem_rvalid_i   (imem_rvalid),
      .imem_rdata_i    (imem_rdata),
      .redirect_i      (redirect),
      .redirect_addr_i (redirect_addr),
      .instr_o         (instr),
      .instr_pc_o      (instr_pc),
      .instr_valid_o   (instr_valid),
      .instr_ready_i   (instr_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check outputs 1ns later.
   task automatic step(input string nm, input vec_t v);
      @(negedge clk);
      fetch_en      = v.en;
      imem_gnt      = v.gnt;
      imem_rvalid   = v.rv;
      imem_rdata    = v.rdata;
      instr_ready   = v.rdy;
      redirect      = v.redir;
      redirect_addr = v.raddr;
      #1;
      chk({nm, ".req"}, {31'b0, imem_req}, {31'b0, v.e_req});
      if (v.e_req) chk({nm, ".addr"}, imem_addr, v.e_addr);
      chk({nm, ".vld"}, {31'b0, instr_valid}, {31'b0, v.e_vld});
      if (v.e_vld) begin
         chk({nm, ".instr"}, instr, v.e_instr);
         chk({nm, ".pc"}, instr_pc, v.e_pc);
      end
   endtask

   task automatic reset_check(input string nm);
      @(negedge clk);
      rst = 1'b1; fetch_en = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0;
      redirect = 1'b0; instr_ready = 1'b0;
      @(negedge clk);
      #1;
      chk({nm, ".req"}, {31'b0, imem_req}, 32'h0);
      chk({nm, ".vld"}, {31'b0, instr_valid}, 32'h0);
      chk({nm, ".instr"}, instr, 32'h0);
      chk({nm, ".pc"}, instr_pc, 32'h0);
      rst = 1'b0; fetch_en = 1'b0; imem_gnt = 1'b0;
   endtask

   initial begin
      //          en   gnt  rv   rdata         rdy  redir raddr  | req  addr          vld  instr         pc
      tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b0,32'h0,        32'h0};
      tbl[1]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b1,32'h0000_0080,1'b0,32'h0,        32'h0};
      tbl[2]  = '{1'b1,1'b1,1'b1,32'hC0DE_0080,1'b1,1'b0,32'h0,  1'b1,32'h0000_0084,1'b0,32'h0,        32'h0};
      tbl[3]  = '{1'b1,1'b1,1'b1,32'hC0DE_0084,1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_0080,32'h80};
      tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b1,32'h0000_0088,1'b1,32'hC0DE_0084,32'h84};
      tbl[5]  = '{1'b1,1'b1,1'b1,32'hC0DE_0088,1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_0084,32'h84};
      tbl[6]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_0084,32'h84};
      tbl[7]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_0084,32'h84};
      tbl[8]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_0084,32'h84};
      tbl[9]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b1,32'h0000_008C,1'b1,32'hC0DE_0088,32'h88};
      tbl[10] = '{1'b1,1'b1,1'b1,32'hC0DE_008C,1'b1,1'b0,32'h0,  1'b1,32'h0000_0090,1'b0,32'h0,        32'h0};
      tbl[11] = '{1'b0,1'b1,1'b1,32'hC0DE_0090,1'b0,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_008C,32'h8C};
      tbl[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_008C,32'h8C};
      tbl[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b1,32'hC0DE_0090,32'h90};
      tbl[14] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,  1'b0,32'h0,        1'b0,32'h0,        32'h0};

      // Power-on reset: request must stay low even with fetch_en high.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst0.req", {31'b0, imem_req}, 32'h0);
      chk("rst0.vld", {31'b0, instr_valid}, 32'h0);
      chk("rst0.instr", instr, 32'h0);
      chk("rst0.pc", instr_pc, 32'h0);
      rst = 1'b0; fetch_en = 1'b0; imem_gnt = 1'b0;

      // Streaming, credit limit, back-pressure, fetch_en low drain.
      for (int i = 0; i < 15; i++) begin
         step($sformatf("tbl[%0d]", i), tbl[i]);
      end

      // Redirect to 0x1002 with two responses in flight: both dropped.
      step("B1", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0000_0094,1'b0,32'h0,32'h0});
      step("B2", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0000_0098,1'b0,32'h0,32'h0});
      step("B3", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,1'b1,32'h0000_1002,  1'b0,32'h0,1'b0,32'h0,32'h0});
      step("B4", vec_t'{1'b1,1'b0,1'b1,32'hDEAD_0094,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,32'h0});
      step("B5", vec_t'{1'b1,1'b1,1'b1,32'hDEAD_0098,1'b1,1'b0,32'h0,  1'b1,32'h0000_1000,1'b0,32'h0,32'h0});
      step("B6", vec_t'{1'b0,1'b0,1'b1,32'hC0DE_1000,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,32'h0});
      step("B7", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hC0DE_1000,32'h1000});
      step("B8", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h0,1'b0,32'h0,32'h0});

      // gnt withheld 3 cycles across a redirect to 0x200: req/addr held, response dropped.
      step("C1", vec_t'{1'b1,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0000_1004,1'b0,32'h0,32'h0});
      step("C2", vec_t'{1'b1,1'b0,1'b0,32'h0,1'b1,1'b1,32'h0000_0200,  1'b1,32'h0000_1004,1'b0,32'h0,32'h0});
      step("C3", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0000_1004,1'b0,32'h0,32'h0});
      step("C4", vec_t'{1'b0,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0000_1004,1'b0,32'h0,32'h0});
      step("C5", vec_t'{1'b1,1'b1,1'b1,32'hDEAD_1004,1'b1,1'b0,32'h0,  1'b1,32'h0000_0200,1'b0,32'h0,32'h0});
      step("C6", vec_t'{1'b0,1'b0,1'b1,32'hC0DE_0200,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,32'h0});
      step("C7", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hC0DE_0200,32'h200});
      step("C8", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h0,1'b0,32'h0,32'h0});

      // Unaligned redirect to the top word, then PC wrap to 0; fill the buffer.
      step("D1", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b1,32'hFFFF_FFFF,  1'b0,32'h0,1'b0,32'h0,32'h0});
      step("D2", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'hFFFF_FFFC,1'b0,32'h0,32'h0});
      step("D3", vec_t'{1'b1,1'b1,1'b1,32'hC0DE_FFFC,1'b1,1'b0,32'h0,  1'b1,32'h0000_0000,1'b0,32'h0,32'h0});
      step("D4", vec_t'{1'b0,1'b0,1'b1,32'hC0DE_0000,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b1,32'hC0DE_FFFC,32'hFFFF_FFFC});
      step("D5", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h0000_0004,1'b1,32'hC0DE_0000,32'h0});
      step("D6", vec_t'{1'b1,1'b1,1'b1,32'hC0DE_0004,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b1,32'hC0DE_0000,32'h0});
      step("D7", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hC0DE_0000,32'h0});

      // Reset with the buffer full, then fetch restarts at the boot address.
      reset_check("rst1");
      step("R1", vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0000_0080,1'b0,32'h0,32'h0});
      step("R2", vec_t'{1'b0,1'b0,1'b1,32'hC0DE_0080,1'b1,1'b0,32'h0,  1'b0,32'h0,1'b0,32'h0,32'h0});
      step("R3", vec_t'{1'b0,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h0,1'b1,32'hC0DE_0080,32'h80});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of control_unit; supplies the 32-bit instruction that control_unit decodes.
- Owns the fetch PC.
- Issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO.
- Hands instructions plus PC downstream with valid/ready.
- Accepts PC redirects (branch/jump), flushing buffered and in-flight words.

Parameters:
BOOT_ADDR, 32'h0000_0080, fetch PC after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2; also the maximum outstanding requests.

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  synchronous, active-high reset
fetch_en_i  input  1  permits new memory requests when high
imem_req_o  output  1  memory request valid
imem_addr_o  output  32  word address of request; [1:0] always 0
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid; in-order, one per granted request
imem_rdata_i  input  32  read data
redirect_i  input  1  load new fetch PC, flush pipeline contents
redirect_addr_i  input  32  target PC; [1:0] ignored (treated as 0)
instr_o  output  32  instruction to control_unit
instr_pc_o  output  32  PC of instr_o
instr_valid_o  output  1  instr_o/instr_pc_o valid
instr_ready_i  input  1  downstream accepts this cycle

Behaviour:
- Reset (rst_i high at edge):
  - fetch_pc = BOOT_ADDR, resp_pc = BOOT_ADDR.
  - FIFO empty; outstanding = 0; discard = 0.
  - imem_req_o = 0; instr_valid_o = 0; instr_o = 0; instr_pc_o = 0.
  - Memory shares rst_i; no responses arrive for pre-reset requests.
- Issue rule:
  - imem_req_o = fetch_en_i && (fifo_count + outstanding) < FIFO_DEPTH, or an ungranted request is pending.
  - Same-cycle pops are not credited.
- Request stability:
  - Once req is high without gnt, req and addr hold unchanged until gnt, even across redirect or fetch_en_i low.
  - On req&&gnt: outstanding += 1; fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
- Response:
  - On rvalid: outstanding -= 1.
  - If discard > 0, the word is dropped and discard -= 1.
  - Otherwise {rdata, resp_pc} is pushed and resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows; an assertion checks this.
- Output:
  - instr_valid_o = FIFO non-empty.
  - instr_o/instr_pc_o = FIFO head.
  - Pop on instr_valid_o && instr_ready_i.
  - rvalid at cycle t -> instr_valid_o at t+1.
  - Simultaneous push and pop when full is legal.
- Redirect at cycle t:
  - FIFO flushed; a pop in cycle t is ignored; instr_valid_o = 0 at t+1.
  - fetch_pc = resp_pc = redirect_addr_i & ~3.
  - discard = outstanding after cycle t's gnt/rvalid updates, plus 1 if a request remains ungranted (its later response is dropped).
  - Earliest new request: imem_req_o with the new addr at t+1 (if no ungranted request is held).
- Simultaneous events:
  - Redirect wins over push/pop in the same cycle.
  - An rvalid in the redirect cycle is dropped.
  - gnt and rvalid in the same cycle: outstanding unchanged net.
- fetch_en_i low: no new requests; in-flight responses still collected; FIFO drains normally.

Optional Feature:
FETCH_BYPASS_EN:
- With it: when the FIFO is empty, discard = 0 and no redirect is active, an rvalid word drives instr_o/instr_pc_o/instr_valid_o combinationally in the same cycle; if instr_ready_i is high it is consumed without being pushed, otherwise it is pushed. Latency 0.
- Without it: always registered through the FIFO, latency 1.

Decomposition:
- riscv_cpu_pkg: XLEN = 32; DEFAULT_BOOT_ADDR; typedef fetch_entry_t struct packed {logic [31:0] instr; logic [31:0] pc;}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, with push/pop/flush, full/empty, count.
- The counters (outstanding, discard) and the PC logic stay in fetch_stage.

Test Plan:
- Reset, fetch_en_i=1, memory gnt immediate, rvalid 1 cycle later -> requests at 0x80, 0x84, 0x88...; instr_pc_o sequence 0x80, 0x84 with matching data; never more than 2 outstanding.
- Hold instr_ready_i=0 -> exactly 2 words buffered, imem_req_o drops; release ready -> one pop per cycle, requests resume.
- Redirect to 0x1002 with 2 responses outstanding -> both dropped; next request addr 0x1000; first delivered instr_pc_o = 0x1000.
- gnt withheld 3 cycles while redirect to 0x200 asserted -> req/addr stable until gnt; that response dropped; next request addr 0x200.
- fetch_pc at 0xFFFF_FFFC -> next request addr 0x0000_0000.
- rst_i asserted with FIFO full and valid high -> next cycle instr_valid_o=0, imem_req_o=0, then fetch restarts at 0x80.
